// File: rtl/ecg_phase_gen.sv
// Sample-rate NCO addressing the ECG waveform LUT; registers the LUT's combinational
// output as a valid-qualified sample stream, in continuous or single-beat playback.
module ecg_phase_gen #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24,
    parameter int DIV_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_single,
    input  logic [ACC_W-1:0]  i_ftw,
    input  logic [DIV_W-1:0]  i_div,
    input  logic [DATA_W-1:0] i_lut_data,
    output logic [ADDR_W-1:0] o_lut_addr,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_valid,
    output logic              o_wrap,
    output logic              o_busy,
    output logic [15:0]       o_beat_cnt
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d, ftw_q, ftw_d;
    logic [DIV_W-1:0]    div_q, div_d, div_cnt_q, div_cnt_d;
    logic                single_q, single_d;
    logic                fetch_q, fetch_d, wrap_q, wrap_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                valid_q, valid_d, owrap_q, owrap_d;
    logic [15:0]         beat_q, beat_d;
    logic                run, start_go, kill, tick;
    logic [ACC_W:0]      sum;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ftw_d     = ftw_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        single_d  = single_q;
        beat_d    = beat_q;
        fetch_d   = 1'b0;
        wrap_d    = 1'b0;

        run      = (state_q == RUN);
        start_go = i_start && !i_stop && (i_ftw != '0);
        // A stop or restart in RUN discards anything still in flight.
        kill     = run && (i_stop || start_go);
        tick     = run && (div_cnt_q == div_q);
        sum      = {1'b0, acc_q} + {1'b0, ftw_q};

        valid_d  = fetch_q && !kill;
        owrap_d  = wrap_q && !kill;
        sample_d = valid_d ? i_lut_data : sample_q;

        if (run && i_stop) begin
            state_d = IDLE;
        end else if (start_go) begin
            state_d   = RUN;
            ftw_d     = i_ftw;
            div_d     = i_div;
            single_d  = i_single;
            acc_d     = '0;
            div_cnt_d = '0;
            beat_d    = '0;
            fetch_d   = 1'b1;
        end else if (run) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                if (!sum[ACC_W]) begin
                    acc_d   = sum[ACC_W-1:0];
                    fetch_d = 1'b1;
                end else begin
                    wrap_d = 1'b1;
                    if (beat_q != 16'hFFFF) beat_d = beat_q + 16'd1;
                    // Single beat ends on carry; the wrapped sample is never fetched.
                    if (single_q) begin
                        state_d = IDLE;
                    end else begin
                        acc_d   = sum[ACC_W-1:0];
                        fetch_d = 1'b1;
                    end
                end
            end
        end
        addr_d = acc_d[ACC_W-1 -: ADDR_W];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ftw_q     <= '0;
            div_q     <= '0;
            div_cnt_q <= '0;
            single_q  <= 1'b0;
            fetch_q   <= 1'b0;
            wrap_q    <= 1'b0;
            addr_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            owrap_q   <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ftw_q     <= ftw_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            single_q  <= single_d;
            fetch_q   <= fetch_d;
            wrap_q    <= wrap_d;
            addr_q    <= addr_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            owrap_q   <= owrap_d;
            beat_q    <= beat_d;
        end
    end

    assign o_lut_addr = addr_q;
    assign o_sample   = sample_q;
    assign o_valid    = valid_q;
    assign o_wrap     = owrap_q;
    assign o_busy     = (state_q == RUN);
    assign o_beat_cnt = beat_q;
endmodule

// File: tb/tb_ecg_phase_gen.sv
// Bench for ecg_phase_gen: runs are modelled as arithmetic sample schedules pushed into a
// scoreboard queue; a negedge monitor pops and compares every o_valid / o_wrap event.
module tb_ecg_phase_gen;
    logic        clk, rst;
    logic        i_start, i_stop, i_single;
    logic [31:0] i_ftw;
    logic [15:0] i_div;
    logic [23:0] i_lut_data;
    logic [9:0]  o_lut_addr;
    logic [23:0] o_sample;
    logic        o_valid, o_wrap, o_busy;
    logic [15:0] o_beat_cnt;

    int checks = 0;
    int failures = 0;
    longint cyc = 0;
    logic [23:0] last_sample = '0;

    typedef struct {
        longint      cyc;
        logic        valid;
        logic [23:0] sample;
        logic        wrap;
    } exp_t;
    exp_t q[$];

    ecg_phase_gen dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_stop(i_stop),
        .i_single(i_single), .i_ftw(i_ftw), .i_div(i_div), .i_lut_data(i_lut_data),
        .o_lut_addr(o_lut_addr), .o_sample(o_sample), .o_valid(o_valid),
        .o_wrap(o_wrap), .o_busy(o_busy), .o_beat_cnt(o_beat_cnt)
    );

    function automatic logic [23:0] lut_f(input logic [9:0] a);
        logic [23:0] x;
        x = {14'd0, a} * 24'd40503;
        return x ^ 24'h5A5A5A;
    endfunction

    assign i_lut_data = lut_f(o_lut_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sample n is started by tick n (n=0 is the start itself), one tick per d+1 clocks,
    // and shows up 2 clocks after its tick unless a stop/restart in cycle p cuts it off.
    task automatic model_run(input longint s, input longint p, input logic [31:0] ftw,
                             input int d, input bit single, output int beats);
        logic [63:0] prod, prodp;
        longint t;
        bit carry;
        exp_t e;
        beats = 0;
        for (longint n = 0; ; n++) begin
            t = s + n * (d + 1);
            if (t >= p) break;
            prod  = 64'(n) * 64'(ftw);
            prodp = (n > 0) ? 64'(n - 1) * 64'(ftw) : 64'd0;
            carry = (n > 0) && (prod[63:32] != prodp[63:32]);
            if (single && carry) begin
                beats++;
                e.cyc = t + 2; e.valid = 1'b0; e.sample = '0; e.wrap = 1'b1;
                q.push_back(e);
                break;
            end
            if (carry && beats < 65535) beats++;
            if (t + 2 <= p) begin
                e.cyc = t + 2; e.valid = 1'b1; e.sample = lut_f(prod[31:22]); e.wrap = carry;
                q.push_back(e);
                last_sample = e.sample;
            end
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++; failures++;
            $display("FAIL missed_event: expected event at cycle %0d did not occur (now %0d)",
                     q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (o_valid || o_wrap) begin
            checks++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                failures++;
                $display("FAIL unexpected_event: valid=%0b wrap=%0b sample=%0h at cycle %0d, expected none",
                         o_valid, o_wrap, o_sample, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (o_valid !== e.valid || o_wrap !== e.wrap ||
                    (e.valid && o_sample !== e.sample)) begin
                    failures++;
                    $display("FAIL event: valid=%0b wrap=%0b sample=%0h, expected valid=%0b wrap=%0b sample=%0h (cycle %0d)",
                             o_valid, o_wrap, o_sample, e.valid, e.wrap, e.sample, cyc);
                end
            end
        end
    end

    task automatic step(input bit noise);
        @(posedge clk); #1;
        if (noise) begin
            i_ftw    = $urandom;
            i_div    = 16'($urandom_range(0, 7));
            i_single = 1'($urandom_range(0, 1));
        end
    endtask

    // kind 0: end with a stop pulse and check the idle state; kind 1: return so the caller restarts.
    task automatic do_run(input logic [31:0] ftw, input int d, input bit single,
                          input int len, input int kind);
        longint s;
        int beats;
        s = cyc;
        i_start = 1'b1; i_ftw = ftw; i_div = 16'(d); i_single = single;
        model_run(s, s + len, ftw, d, single, beats);
        step(1'b0);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
        for (int i = 1; i < len; i++) step(1'b1);
        if (kind == 0) begin
            i_stop = 1'b1;
            step(1'b1);
            i_stop = 1'b0;
            chk("busy_after_stop", o_busy, 0);
            repeat (3) step(1'b1);
            chk("beat_cnt", o_beat_cnt, beats);
            chk("sample_hold", o_sample, last_sample);
            chk("queue_drained", q.size(), 0);
        end
    endtask

    initial begin
        int d, len;
        logic [31:0] f;
        rst = 1'b1; i_start = 0; i_stop = 0; i_single = 0; i_ftw = 0; i_div = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", o_lut_addr, 0);
        chk("rst_sample", o_sample, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_wrap", o_wrap, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_beat", o_beat_cnt, 0);
        rst = 1'b0;
        step(1'b0);

        do_run(32'h0040_0000, 0, 1'b0, 2100, 0);
        do_run(32'h0080_0000, 3, 1'b1, 2200, 0);
        chk("single_sample_1022", last_sample, lut_f(10'd1022));

        // Stop one cycle after a tick.
        do_run(32'h0123_4567, 3, 1'b0, 4 * 9 + 1, 0);

        // Start with stop in IDLE, then start with ftw = 0: both must be ignored.
        i_start = 1; i_stop = 1; i_ftw = 32'h1000_0000;
        step(1'b0);
        i_start = 0; i_stop = 0;
        chk("start_stop_idle", o_busy, 0);
        i_start = 1; i_ftw = 32'h0;
        step(1'b0);
        i_start = 0;
        chk("ftw0_idle", o_busy, 0);
        repeat (3) step(1'b0);
        chk("ftw0_sample_hold", o_sample, last_sample);

        // Restart from RUN at address 700.
        do_run(32'h0040_0000, 0, 1'b0, 701, 1);
        chk("addr_before_restart", o_lut_addr, 700);
        do_run(32'h0040_0000, 0, 1'b0, 12, 0);

        for (int r = 0; r < 30; r++) begin
            f   = $urandom_range(32'h0800_0000, 32'hFFFF_FFFF);
            if (r % 7 == 0) f = 32'h1000_0000;
            d   = $urandom_range(0, 4);
            len = $urandom_range(10, 160);
            do_run(f, d, 1'($urandom_range(0, 1)), len, 0);
            repeat ($urandom_range(0, 3)) step(1'b1);
        end

        // Asynchronous reset between edges during RUN.
        do_run(32'h0200_0000, 1, 1'b0, 51, 1);
        #2 rst = 1'b1;
        #1;
        q.delete();
        last_sample = '0;
        chk("arst_busy", o_busy, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_addr", o_lut_addr, 0);
        chk("arst_sample", o_sample, 0);
        chk("arst_beat", o_beat_cnt, 0);
        step(1'b0);
        rst = 1'b0;
        i_stop = 1'b1;
        step(1'b0);
        i_stop = 1'b0;
        repeat (3) step(1'b0);
        chk("post_rst_busy", o_busy, 0);
        chk("post_rst_addr", o_lut_addr, 0);
        chk("post_rst_sample", o_sample, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
